// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state encoding,
// handshake levels and the ALU-op codes that select DIV/DIVU in EX.
package div_pkg;

  localparam logic [7:0] ExeDivOp  = 8'b0001_1010;
  localparam logic [7:0] ExeDivuOp = 8'b0001_1011;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference on no borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             dividend_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             unused_rem_msb;

  // rem_i < divisor always holds, so its top bit is zero and drops out of the shift
  assign unused_rem_msb = rem_i[WIDTH];
  assign shifted        = {rem_i[WIDTH-1:0], dividend_msb_i};
  assign diff           = {1'b0, shifted} - {2'b00, divisor_i};
  assign q_bit_o        = ~diff[WIDTH+1];
  assign rem_o          = q_bit_o ? diff[WIDTH:0] : shifted;

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider; states: FREE idle/accept | BY_ZERO divisor 0 |
// ON one quotient bit per clock | END result held until start_i drops.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic               mode_q, mode_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH:0]     rem_nxt;
  logic               q_bit;
  logic [WIDTH-1:0]   dvd_nxt;
  logic [WIDTH-1:0]   op1_abs, op2_abs;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i          (rem_q),
    .dividend_msb_i (dvd_q[WIDTH-1]),
    .divisor_i      (dvs_q),
    .rem_o          (rem_nxt),
    .q_bit_o        (q_bit)
  );

  // Quotient bits fill the dividend register from the bottom as it shifts out
  assign dvd_nxt  = {dvd_q[WIDTH-2:0], q_bit};
  assign op1_abs  = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign op2_abs  = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  assign quot_fix = (mode_q && (sign_a_q ^ sign_b_q)) ? -dvd_nxt : dvd_nxt;
  assign rem_fix  = (mode_q && sign_a_q) ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      mode_q   <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      mode_q   <= mode_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    mode_d   = mode_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    result_d = result_q;
    ready_d  = DivResultNotReady;
    unique case (state_q)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d  = DivOn;
            dvd_d    = op1_abs;
            dvs_d    = op2_abs;
            rem_d    = '0;
            cnt_d    = '0;
            mode_d   = signed_div_i;
            sign_a_d = opdata1_i[WIDTH-1];
            sign_b_d = opdata2_i[WIDTH-1];
          end
        end
      end
      DivByZero: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          state_d  = DivEnd;
          result_d = '0;
          ready_d  = DivResultReady;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          result_d = '0;
        end else begin
          rem_d = rem_nxt;
          dvd_d = dvd_nxt;
          if (cnt_q == CntLast) begin
            cnt_d    = '0;
            state_d  = DivEnd;
            result_d = {rem_fix, quot_fix};
            ready_d  = DivResultReady;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          state_d  = DivFree;
          result_d = '0;
        end else begin
          ready_d = DivResultReady;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit at WIDTH=32 and WIDTH=8 against
// an integer-arithmetic reference model.
module tb_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sgn32, start32, annul32, rdy32;
  logic [31:0] a32, b32;
  logic [63:0] res32;
  logic        sgn8, start8, annul8, rdy8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .signed_div_i(sgn32), .opdata1_i(a32), .opdata2_i(b32),
    .start_i(start32), .annul_i(annul32), .result_o(res32), .ready_o(rdy32)
  );

  div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .signed_div_i(sgn8), .opdata1_i(a8), .opdata2_i(b8),
    .start_i(start8), .annul_i(annul8), .result_o(res8), .ready_o(rdy8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: truncating integer division on sign-interpreted operands
  function automatic logic [63:0] model(input int w, input bit sgn,
                                        input logic [31:0] a, input logic [31:0] b);
    longint mask, av, bv, q, r;
    mask = (longint'(1) << w) - 1;
    av = longint'(a) & mask;
    bv = longint'(b) & mask;
    if (bv == 0) return 64'd0;
    if (sgn && ((av >> (w - 1)) & 1) == 1) av = av - (longint'(1) << w);
    if (sgn && ((bv >> (w - 1)) & 1) == 1) bv = bv - (longint'(1) << w);
    q = av / bv;
    r = av % bv;
    return 64'(((r & mask) << w) | (q & mask));
  endfunction

  function automatic logic cur_rdy(input bit w8);
    return w8 ? rdy8 : rdy32;
  endfunction

  function automatic logic [63:0] cur_res(input bit w8);
    return w8 ? {48'd0, res8} : res32;
  endfunction

  task automatic drive(input bit w8, input bit s, input logic [31:0] a, input logic [31:0] b,
                       input bit st, input bit an);
    if (w8) begin
      sgn8 = s; a8 = a[7:0]; b8 = b[7:0]; start8 = st; annul8 = an;
    end else begin
      sgn32 = s; a32 = a; b32 = b; start32 = st; annul32 = an;
    end
  endtask

  task automatic run_op(input bit w8, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input logic [63:0] exp_const, input bit use_const);
    int w;
    int n;
    int exp_lat;
    logic [63:0] expv;
    w = w8 ? 8 : 32;
    expv = model(w, sgn, a, b);
    exp_lat = (w8 ? (b[7:0] == 8'd0) : (b == 32'd0)) ? 1 : w;
    @(negedge clk);
    drive(w8, sgn, a, b, 1'b1, 1'b0);
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!cur_rdy(w8) && n < 200);
    chk({tag, " latency"}, 64'(n), 64'(exp_lat));
    chk({tag, " result"}, cur_res(w8), expv);
    if (use_const) chk({tag, " plan"}, cur_res(w8), exp_const);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(w8, ~sgn, $urandom, $urandom, 1'b1, i == 2);
      @(posedge clk); #1;
      chk({tag, " hold ready"}, {63'd0, cur_rdy(w8)}, 64'd1);
      chk({tag, " hold result"}, cur_res(w8), expv);
    end
    @(negedge clk);
    drive(w8, sgn, a, b, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk({tag, " drop ready"}, {63'd0, cur_rdy(w8)}, 64'd0);
    chk({tag, " drop result"}, cur_res(w8), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    logic [31:0] ra, rb;
    bit rs, rw8;
    int sel;

    rst = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready32", {63'd0, rdy32}, 64'd0);
    chk("reset result32", res32, 64'd0);
    chk("reset ready8", {63'd0, rdy8}, 64'd0);
    chk("reset result8", {48'd0, res8}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op(0, 0, 32'd100, 32'd7, "u100_7", 64'h00000002_0000000E, 1);
    run_op(0, 1, 32'hFFFF_FFF9, 32'd2, "s-7_2", 64'hFFFFFFFF_FFFFFFFD, 1);
    run_op(0, 1, 32'd7, 32'hFFFF_FFFE, "s7_-2", 64'h00000001_FFFFFFFD, 1);
    run_op(0, 0, 32'd5, 32'd0, "div0", 64'd0, 1);
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, "minneg", 64'h00000000_80000000, 1);
    run_op(1, 0, 32'd200, 32'd13, "w8 u200_13", 64'h050F, 1);
    run_op(1, 1, 32'h80, 32'hFF, "w8 minneg", 64'h0080, 1);

    // annul on the 10th ON edge
    @(negedge clk);
    drive(0, 0, 32'd1000, 32'd7, 1'b1, 1'b0);
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul32 = 1'b1;
    @(posedge clk); #1;
    chk("annul ready", {63'd0, rdy32}, 64'd0);
    chk("annul result", res32, 64'd0);
    @(negedge clk);
    drive(0, 0, 32'd1000, 32'd7, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen = seen | rdy32;
    end
    chk("annul no ready", {63'd0, seen}, 64'd0);
    run_op(0, 0, 32'd9, 32'd3, "after annul 9_3", 64'h00000000_00000003, 1);

    // annul while in BY_ZERO
    @(negedge clk);
    drive(0, 0, 32'd5, 32'd0, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    annul32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 32'd5, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("annul byzero ready", {63'd0, rdy32}, 64'd0);

    // reset at ON edge 20
    @(negedge clk);
    drive(0, 1, 32'hFFFF_0000, 32'd3, 1'b1, 1'b0);
    @(posedge clk);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start32 = 1'b0;
    @(posedge clk); #1;
    chk("rst mid-on ready", {63'd0, rdy32}, 64'd0);
    chk("rst mid-on result", res32, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(0, 0, 32'd123456, 32'd789, "after rst", 64'd0, 0);

    // reset while holding a result in END
    @(negedge clk);
    drive(0, 0, 32'd100, 32'd7, 1'b1, 1'b0);
    sel = 0;
    do begin
      @(posedge clk); #1;
      sel++;
    end while (!rdy32 && sel < 200);
    chk("end pre-rst result", res32, 64'h00000002_0000000E);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst in end ready", {63'd0, rdy32}, 64'd0);
    chk("rst in end result", res32, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    start32 = 1'b0;
    @(posedge clk); #1;
    chk("rst in end stays idle", {63'd0, rdy32}, 64'd0);

    for (int k = 0; k < 40; k++) begin
      rw8 = $urandom_range(0, 1) == 1;
      rs  = $urandom_range(0, 1) == 1;
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: begin ra = rw8 ? 32'h80 : 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = $urandom_range(1, 15);
        4: ra = $urandom_range(0, 20);
        default: ;
      endcase
      run_op(rw8, rs, ra, rb, "random", 64'd0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
